// File: rtl/spi_arb_pkg.sv
// Shared state encoding and helpers for the SPI transaction arbiter.
// The optional transfer watchdog is enabled by defining SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StResp
  } arb_state_e;

  localparam int unsigned GapCyclesDef     = 4;
  localparam int unsigned TimeoutCyclesDef = 1024;

  // Width of the shared gap/watchdog counter: $clog2(max(gap, timeout) + 1), at least 1.
  function automatic int unsigned cnt_width(int unsigned gap, int unsigned timeout);
    int unsigned m;
    m = (gap > timeout) ? gap : timeout;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

  function automatic logic [31:0] slv_onehot(int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin select: first set request searching upward from ptr_i + 1,
// wrapping at NumReq. Produces a one-hot grant and its encoded index.
module spi_rr_picker #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = {1'b0, ptr_i} + (IdxW + 1)'(k);
      if (cand >= (IdxW + 1)'(NumReq)) begin
        cand = cand - (IdxW + 1)'(NumReq);
      end
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found                   = 1'b1;
        gnt_o[cand[IdxW-1:0]]   = 1'b1;
        idx_o                   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts transfers stuck on m_busy_i.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned SLV_W          = 2,
  parameter int unsigned GAP_CYCLES     = GapCyclesDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*SLV_W-1:0]      req_slave_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          m_start_tx_o,
  output logic [DATA_WIDTH-1:0]         m_tx_data_o,
  output logic [NUM_SLAVES-1:0]         m_ss_sel_o,
  input  logic                          m_busy_i,
  input  logic [DATA_WIDTH-1:0]         m_rx_data_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);

  arb_state_e              state_q;
  logic [IdxW-1:0]         ptr_q;
  logic [CntW-1:0]         gap_q;
  logic [NUM_REQ-1:0]      win_q;
  logic [DATA_WIDTH-1:0]   tx_q;
  logic [DATA_WIDTH-1:0]   rx_q;
  logic                    err_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic [NUM_REQ-1:0]      done_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_err_q;
  logic                    start_q;
  logic [NUM_SLAVES-1:0]   ss_q;

  logic [NUM_REQ-1:0]      gnt;
  logic [IdxW-1:0]         gnt_idx;
  logic [SLV_W-1:0]        win_slave;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    slv_valid;
  logic                    wd_hit;

  spi_rr_picker #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_picker (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign win_slave = req_slave_i[32'(gnt_idx) * SLV_W +: SLV_W];
  assign win_data  = req_data_i[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign slv_valid = (32'(win_slave) < NUM_SLAVES);

`ifdef SPI_ARB_TIMEOUT_EN
  logic [CntW-1:0] wd_q;

  // Counts only while stalled in a wait state; any state entry restarts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if ((state_q == StWaitBusy && !m_busy_i) ||
                 (state_q == StWaitDone && m_busy_i)) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  assign wd_hit = (wd_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= IdxW'(NUM_REQ - 1);
      gap_q      <= '0;
      win_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      err_q      <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      start_q    <= 1'b0;
      ss_q       <= '0;
    end else begin
      ack_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end else if (|req_i) begin
            ack_q <= gnt;
            win_q <= gnt;
            ptr_q <= gnt_idx;
            if (slv_valid) begin
              tx_q    <= win_data;
              ss_q    <= NUM_SLAVES'(slv_onehot(32'(win_slave)));
              start_q <= 1'b1;
              err_q   <= 1'b0;
              state_q <= StIssue;
            end else begin
              // Bad slave index: answer immediately without touching the master.
              rx_q    <= '0;
              err_q   <= 1'b1;
              state_q <= StResp;
            end
          end
        end
        StIssue: begin
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (m_busy_i) begin
            state_q <= StWaitDone;
          end else if (wd_hit) begin
            rx_q    <= '0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end
        end
        StWaitDone: begin
          if (!m_busy_i) begin
            rx_q    <= m_rx_data_i;
            state_q <= StResp;
          end else if (wd_hit) begin
            rx_q    <= '0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          done_q     <= win_q;
          rsp_data_q <= rx_q;
          rsp_err_q  <= err_q;
          ss_q       <= '0;
          gap_q      <= CntW'(GAP_CYCLES);
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o        = ack_q;
  assign done_o       = done_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign m_start_tx_o = start_q;
  assign m_tx_data_o  = tx_q;
  assign m_ss_sel_o   = ss_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a simple SPI master model.
// The watchdog section runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_txn_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 2;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR*SW-1:0] req_slave;
  logic [NR-1:0]    ack_o;
  logic [NR-1:0]    done_o;
  logic [DW-1:0]    rsp_data_o;
  logic             rsp_err_o;
  logic             m_start_tx_o;
  logic [DW-1:0]    m_tx_data_o;
  logic [1:0]       m_ss_sel_o;
  logic             m_busy;
  logic [DW-1:0]    m_rx;

  int n_checks = 0;
  int n_fail   = 0;

  // Master model controls
  int         busy_len  = 3;
  logic [DW-1:0] rx_word = '0;
  logic       master_en = 1'b1;

  // Monitor state
  int  ack_cnt  [NR];
  int  done_cnt [NR];
  int  start_cnt = 0;
  int  overlap   = 0;
  time start_t[$];
  time fall_t[$];

  spi_txn_arbiter #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (2),
    .SLV_W          (SW),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .req_data_i   (req_data),
    .req_slave_i  (req_slave),
    .ack_o        (ack_o),
    .done_o       (done_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o),
    .m_start_tx_o (m_start_tx_o),
    .m_tx_data_o  (m_tx_data_o),
    .m_ss_sel_o   (m_ss_sel_o),
    .m_busy_i     (m_busy),
    .m_rx_data_i  (m_rx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for ack (which=0) or done (which=1) on any requester in mask; n = negedges waited.
  task automatic wait_ev(input string tag, input int which, input logic [NR-1:0] mask,
                         input int bound, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      if (((which == 0) ? ack_o : done_o) & mask) hit = 1'b1;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_data[i*DW +: DW]  = d;
    req_slave[i*SW +: SW] = s;
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Master: busy rises the cycle after start, stays high busy_len cycles, returns rx_word.
  initial begin
    m_busy = 1'b0;
    m_rx   = '0;
    forever begin
      @(negedge clk);
      if (m_start_tx_o && master_en) begin
        @(negedge clk);
        m_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        m_busy = 1'b0;
        m_rx   = rx_word;
        fall_t.push_back($time);
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      ack_cnt[i]  = 0;
      done_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (ack_o[i])  ack_cnt[i]++;
        if (done_o[i]) done_cnt[i]++;
      end
      if ((ack_o & done_o) != '0) overlap++;
      if (m_start_tx_o) begin
        start_cnt++;
        start_t.push_back($time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    int s0, a3, d3, d0;
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    req_slave = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_start", 32'(m_start_tx_o), 32'd0);
    check("rst_ss", 32'(m_ss_sel_o), 32'd0);
    check("rst_rsp", {15'd0, rsp_err_o, rsp_data_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesting continuously: pointer starts at 3, so order is 0,1,2,3,0
    busy_len = 3;
    rx_word  = 16'h0000;
    for (int i = 0; i < NR; i++) set_req(i, DW'(16'hA000 + i), 2'd0);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ev("rr_ack", 0, 4'hF, 60, n);
      check("rr_order", 32'(oh_idx(ack_o)), 32'(k % 4));
      check("rr_tx", 32'(m_tx_data_o), 32'(16'hA000 + (k % 4)));
      if (k == 4) req = '0;
    end
    wait_ev("rr_last_done", 1, 4'h1, 60, n);
    repeat (2) @(negedge clk);
    check("rr_starts", 32'(start_t.size()), 32'd5);
    // Busy falls at t; RESP t+1; done t+2; four gap cycles; grant edge; start seen at t+7
    for (int k = 1; k < start_t.size() && k <= fall_t.size() && k < 5; k++)
      check("rr_gap", 32'(int'((start_t[k] - fall_t[k-1]) / 10)), 32'd7);

    // Single request: requester 2, slave 1
    repeat (10) @(negedge clk);
    busy_len = 40;
    rx_word  = 16'hBEEF;
    set_req(2, 16'h1234, 2'd1);
    req = 4'b0100;
    wait_ev("c_ack", 0, 4'b0100, 20, n);
    check("c_ack_lat", 32'(n), 32'd1);
    check("c_ack_val", 32'(ack_o), 32'h4);
    check("c_start", 32'(m_start_tx_o), 32'd1);
    check("c_ss", 32'(m_ss_sel_o), 32'h2);
    check("c_tx", 32'(m_tx_data_o), 32'h1234);
    req = '0;
    @(negedge clk);
    check("c_start_pulse", 32'(m_start_tx_o), 32'd0);
    wait_ev("c_done", 1, 4'b0100, 100, n);
    check("c_done_lat", 32'(n), 32'd42);
    check("c_done_val", 32'(done_o), 32'h4);
    check("c_rsp", 32'(rsp_data_o), 32'hBEEF);
    check("c_err", 32'(rsp_err_o), 32'd0);
    check("c_ss_clr", 32'(m_ss_sel_o), 32'd0);
    check("c_tx_hold", 32'(m_tx_data_o), 32'h1234);
    @(negedge clk);
    check("c_rsp_hold", 32'(rsp_data_o), 32'hBEEF);

    // Invalid slave index 3 on requester 1
    repeat (10) @(negedge clk);
    s0 = start_cnt;
    set_req(1, 16'h5555, 2'd3);
    req = 4'b0010;
    wait_ev("d_ack", 0, 4'b0010, 20, n);
    check("d_ack_val", 32'(ack_o), 32'h2);
    check("d_no_ss", 32'(m_ss_sel_o), 32'd0);
    req = '0;
    @(negedge clk);
    check("d_done", 32'(done_o), 32'h2);
    check("d_err", 32'(rsp_err_o), 32'd1);
    check("d_rsp", 32'(rsp_data_o), 32'd0);
    repeat (5) @(negedge clk);
    check("d_no_start", 32'(start_cnt), 32'(s0));

    // Requester 3 pulses req for one cycle while requester 0 is in flight
    repeat (10) @(negedge clk);
    a3       = ack_cnt[3];
    d3       = done_cnt[3];
    busy_len = 10;
    rx_word  = 16'h1357;
    set_req(0, 16'h0E0E, 2'd0);
    req = 4'b0001;
    wait_ev("e_ack0", 0, 4'b0001, 20, n);
    req = '0;
    repeat (3) @(negedge clk);
    set_req(3, 16'h3333, 2'd1);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    wait_ev("e_done0", 1, 4'b0001, 40, n);
    check("e_rsp", 32'(rsp_data_o), 32'h1357);
    repeat (12) @(negedge clk);
    check("e_no_ack3", 32'(ack_cnt[3]), 32'(a3));
    check("e_no_done3", 32'(done_cnt[3]), 32'(d3));

    // Reset during WAIT_DONE; afterwards requester 0 beats requester 2
    repeat (10) @(negedge clk);
    busy_len = 30;
    rx_word  = 16'h2468;
    set_req(0, 16'hF00D, 2'd1);
    req = 4'b0001;
    wait_ev("f_ack0", 0, 4'b0001, 20, n);
    req = '0;
    repeat (8) @(negedge clk);
    d0 = done_cnt[0];
    set_req(2, 16'h2222, 2'd0);
    req   = 4'b0101;
    rst_n = 1'b0;
    #1;
    check("f_rst_ss", 32'(m_ss_sel_o), 32'd0);
    check("f_rst_tx", 32'(m_tx_data_o), 32'd0);
    check("f_rst_rsp", {15'd0, rsp_err_o, rsp_data_o}, 32'd0);
    check("f_rst_pulses", {24'd0, ack_o, done_o}, 32'd0);
    repeat (40) @(negedge clk);
    rst_n = 1'b1;
    wait_ev("f_ack_after", 0, 4'b0101, 20, n);
    check("f_first", 32'(ack_o), 32'h1);
    check("f_no_abort_done", 32'(done_cnt[0]), 32'(d0));
    req = 4'b0100;
    wait_ev("f_done0", 1, 4'b0001, 60, n);
    check("f_rsp0", 32'(rsp_data_o), 32'h2468);
    wait_ev("f_ack2", 0, 4'b0100, 20, n);
    req = '0;
    wait_ev("f_done2", 1, 4'b0100, 60, n);

`ifdef SPI_ARB_TIMEOUT_EN
    // Master never answers: RESP 64 cycles after WAIT_BUSY entry, done one cycle later
    repeat (10) @(negedge clk);
    master_en = 1'b0;
    set_req(2, 16'h7777, 2'd0);
    req = 4'b0100;
    wait_ev("g_ack", 0, 4'b0100, 20, n);
    req = '0;
    wait_ev("g_done", 1, 4'b0100, 200, n);
    check("g_lat", 32'(n), 32'd66);
    check("g_err", 32'(rsp_err_o), 32'd1);
    check("g_rsp", 32'(rsp_data_o), 32'd0);
    master_en = 1'b1;
    busy_len  = 5;
    rx_word   = 16'h4242;
    set_req(3, 16'h3030, 2'd1);
    req = 4'b1000;
    wait_ev("g_ack3", 0, 4'b1000, 20, n);
    req = '0;
    wait_ev("g_done3", 1, 4'b1000, 40, n);
    check("g_err3", 32'(rsp_err_o), 32'd0);
    check("g_rsp3", 32'(rsp_data_o), 32'h4242);
`endif

    check("ack_done_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
